top_module_switch: RTL and testbench

TOP_MODULE_SWITCH -- requirements
Module: top_module_switch

---
 rtl/switch_pkg.sv | 40 ++++
 rtl/switch_rr_arbiter.sv | 28 ++
 rtl/top_module_switch.sv | 131 +++++++++++++
 tb/tb_top_module_switch.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: flit encoding, head-field layout
// and controller state shared by the switch.
package switch_pkg;

  localparam int DEF_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    HEAD     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_e;

  // Head flit layout; lport is carried unmodified.
  typedef struct packed {
    logic [18:0] rsvd;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [2:0]  lport;
    flit_e       kind;
  } head_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } sw_state_e;

  function automatic logic is_head(
    input logic [1:0] k
  );
    return (k == HEAD) || (k == HEADTAIL);
  endfunction

  function automatic logic is_tail(
    input logic [1:0] k
  );
    return (k == TAIL) || (k == HEADTAIL);
  endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// switch_rr_arbiter: one-hot round-robin pick,
// search starts at ptr and wraps.
module switch_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int idx;

  // Walk offsets high to low so the closest
  // request to ptr is the one left standing.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/top_module_switch.sv
// top_module_switch: merges upstream 2-phase
// flit streams onto one downstream port.
module top_module_switch
  import switch_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int OUTPORTS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gen_enable,
  input  logic [OUTPORTS-1:0]   req_up_i,
  input  logic [WORD_WIDTH-1:0] Data_up_i_0,
  input  logic [WORD_WIDTH-1:0] Data_up_i_1,
  input  logic [WORD_WIDTH-1:0] Data_up_i_2,
  input  logic [WORD_WIDTH-1:0] Data_up_i_3,
  output logic [OUTPORTS-1:0]   ack_up_o,
  input  logic [OUTPORTS-1:0]   PacketEnable_up_i,
  output logic [OUTPORTS-1:0]   Tailpassed_dw_i,
  output logic                  req_dw_o,
  output logic [WORD_WIDTH-1:0] Data_dw0_o,
  input  logic                  ack_dw_i
);

  localparam int PW =
    (OUTPORTS > 1) ? $clog2(OUTPORTS) : 1;

  logic [OUTPORTS-1:0]   req_s1;
  logic [OUTPORTS-1:0]   req_s2;
  logic                  ack_s1;
  logic                  ack_s2;
  logic [WORD_WIDTH-1:0] data_up [4];
  logic [OUTPORTS-1:0]   pending;
  logic [OUTPORTS-1:0]   head_req;
  logic [OUTPORTS-1:0]   arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         gnt_next;
  logic [PW-1:0]         ptr;
  logic [1:0]            kind;
  logic                  ds_free;
  logic                  fwd;
  sw_state_e             state;

  // Data lanes exist for four upstream ports.
  assign data_up[0] = Data_up_i_0;
  assign data_up[1] = Data_up_i_1;
  assign data_up[2] = Data_up_i_2;
  assign data_up[3] = Data_up_i_3;

  assign pending = req_s2 ^ ack_up_o;
  assign ds_free = (req_dw_o == ack_s2);

  always_comb begin
    head_req = '0;
    for (int i = 0; i < OUTPORTS; i++) begin
      head_req[i] = pending[i]
                  & PacketEnable_up_i[i]
                  & is_head(data_up[i][1:0]);
    end
  end

  switch_rr_arbiter #(
    .N  (OUTPORTS),
    .PW (PW)
  ) u_arb (
    .req (head_req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < OUTPORTS; i++) begin
      if (arb_gnt[i]) arb_idx = PW'(i);
    end
  end

  assign kind = data_up[gnt_idx][1:0];
  assign fwd  = (state == ST_BUSY)
              & pending[gnt_idx]
              & ds_free;
  assign gnt_next =
    (gnt_idx == PW'(OUTPORTS - 1)) ?
    '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_s1          <= '0;
      req_s2          <= '0;
      ack_s1          <= 1'b0;
      ack_s2          <= 1'b0;
      ack_up_o        <= '0;
      req_dw_o        <= 1'b0;
      Data_dw0_o      <= '0;
      Tailpassed_dw_i <= '0;
      state           <= ST_IDLE;
      gnt_idx         <= '0;
      ptr             <= '0;
    end else begin
      req_s1 <= req_up_i;
      req_s2 <= req_s1;
      ack_s1 <= ack_dw_i;
      ack_s2 <= ack_s1;
      Tailpassed_dw_i <=
        Tailpassed_dw_i & PacketEnable_up_i;
      unique case (state)
        ST_IDLE: begin
          if (gen_enable && |head_req) begin
            state   <= ST_BUSY;
            gnt_idx <= arb_idx;
          end
        end
        ST_BUSY: begin
          if (fwd) begin
            Data_dw0_o        <= data_up[gnt_idx];
            req_dw_o          <= ~req_dw_o;
            ack_up_o[gnt_idx] <= ~ack_up_o[gnt_idx];
            if (is_tail(kind)) begin
              state                    <= ST_IDLE;
              ptr                      <= gnt_next;
              Tailpassed_dw_i[gnt_idx] <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_module_switch.sv
// tb_top_module_switch: randomized packet traffic
// checked against a round-robin packet model.
module tb_top_module_switch;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic gen_enable;
  logic req_b [4];
  logic pe_b [4];
  logic [W-1:0] dup [4];
  logic [3:0] req_up;
  logic [3:0] pe_up;
  logic [3:0] ack_up;
  logic [3:0] tailp;
  logic req_dw;
  logic ack_dw;
  logic [W-1:0] data_dw;

  assign req_up = {req_b[3], req_b[2], req_b[1], req_b[0]};
  assign pe_up  = {pe_b[3], pe_b[2], pe_b[1], pe_b[0]};

  always #5 clk = ~clk;

  top_module_switch #(
    .WORD_WIDTH (W),
    .OUTPORTS   (4)
  ) dut (
    .clk               (clk),
    .reset             (rst_n),
    .gen_enable        (gen_enable),
    .req_up_i          (req_up),
    .Data_up_i_0       (dup[0]),
    .Data_up_i_1       (dup[1]),
    .Data_up_i_2       (dup[2]),
    .Data_up_i_3       (dup[3]),
    .ack_up_o          (ack_up),
    .PacketEnable_up_i (pe_up),
    .Tailpassed_dw_i   (tailp),
    .req_dw_o          (req_dw),
    .Data_dw0_o        (data_dw),
    .ack_dw_i          (ack_dw)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] pkt [4][$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] out_q [$];
  int model_ptr = 0;
  bit ds_hold = 1'b0;
  bit ds_rand = 1'b0;
  int req_tog = 0;
  int ack_tog [4] = '{0, 0, 0, 0};
  logic last_req = 1'b0;
  logic [3:0] last_ack = 4'b0;

  always @(negedge clk) begin
    if (req_dw !== last_req) req_tog++;
    for (int i = 0; i < 4; i++)
      if (ack_up[i] !== last_ack[i]) ack_tog[i]++;
    last_req = req_dw;
    last_ack = ack_up;
  end

  // Downstream sink: log each new flit, then ack.
  initial begin
    ack_dw = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !ds_hold && req_dw !== ack_dw) begin
        out_q.push_back(data_dw);
        repeat (ds_rand ? int'($urandom_range(2, 0)) : 0)
          @(negedge clk);
        ack_dw = req_dw;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

  // Whole packets leave in round-robin port order.
  function automatic void model_order();
    int p;
    int last;
    last = model_ptr;
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      p = (model_ptr + n) % 4;
      if (pkt[p].size() > 0) begin
        for (int k = 0; k < pkt[p].size(); k++)
          exp_q.push_back(pkt[p][k]);
        last = p;
      end
    end
    if (exp_q.size() > 0) model_ptr = (last + 1) % 4;
  endfunction

  function automatic void clear_pkts();
    for (int p = 0; p < 4; p++) pkt[p].delete();
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    ack_dw = 1'b0;
    for (int p = 0; p < 4; p++) begin
      req_b[p] = 1'b0;
      pe_b[p]  = 1'b0;
      dup[p]   = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    out_q.delete();
  endtask

  task automatic send_port(input int p);
    int t;
    if (pkt[p].size() == 0) return;
    pe_b[p] = 1'b1;
    for (int k = 0; k < pkt[p].size(); k++) begin
      dup[p]   = pkt[p][k];
      req_b[p] = ~req_b[p];
      t = 0;
      while (ack_up[p] !== req_b[p] && t < 400) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (ack_up[p] !== req_b[p]) begin
        errors++;
        $display("FAIL ack_wait p%0d f%0d: ack=%b want %b",
                 p, k, ack_up[p], req_b[p]);
        return;
      end
    end
    checks++;
    if (tailp[p] !== 1'b1) begin
      errors++;
      $display("FAIL tailpassed_set p%0d: got %b want 1",
               p, tailp[p]);
    end
    pe_b[p] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tailp[p] !== 1'b0) begin
      errors++;
      $display("FAIL tailpassed_clr p%0d: got %b want 0",
               p, tailp[p]);
    end
  endtask

  task automatic send_all();
    fork
      send_port(0);
      send_port(1);
      send_port(2);
      send_port(3);
    join
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gen_enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      req_b[p] = 1'b0;
      pe_b[p]  = 1'b0;
      dup[p]   = '1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ack_up !== 4'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", ack_up);
    end
    checks++;
    if (req_dw !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_dw: got %b want 0", req_dw);
    end
    checks++;
    if (data_dw !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", data_dw);
    end
    checks++;
    if (tailp !== 4'b0) begin
      errors++;
      $display("FAIL reset_tailp: got %b want 0", tailp);
    end
    do_reset();
  endtask

  task automatic test_single();
    int r0;
    clear_pkts();
    pkt[2] = {32'h0000_0401, 32'h0, 32'h0000_0002};
    model_order();
    out_q.delete();
    r0 = req_tog;
    send_all();
    checks++;
    if (req_tog - r0 != 3) begin
      errors++;
      $display("FAIL single_toggles: got %0d want 3",
               req_tog - r0);
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d want %0d",
               out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_flit %0d: got %h want %h",
                 i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    clear_pkts();
    pkt[0] = {32'h401, 32'h0, 32'hFFFF_FFFC,
              32'hFFFF_FFFC, 32'h2};
    pkt[1] = {32'h401, 32'h0, 32'hFFFF_FFFC,
              32'hFFFF_FFFC, 32'h2};
    pkt[2] = {32'h401, 32'h0, 32'h2};
    pkt[3] = {32'h401, 32'h0, 32'h2};
    model_order();
    send_all();
    checks++;
    if (out_q.size() != 16) begin
      errors++;
      $display("FAIL all_count: got %0d want 16",
               out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL all_flit %0d: got %h want %h",
                 i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int a0;
    clear_pkts();
    pkt[0] = {32'h0000_1a25, 32'h0000_5550,
              32'hABCD_0002};
    model_order();
    out_q.delete();
    ds_hold = 1'b1;
    r0 = req_tog;
    a0 = ack_tog[0];
    fork
      send_port(0);
      begin
        repeat (25) @(negedge clk);
        checks++;
        if (req_tog - r0 != 1) begin
          errors++;
          $display("FAIL hold_req_toggles: got %0d want 1",
                   req_tog - r0);
        end
        checks++;
        if (ack_tog[0] - a0 != 1) begin
          errors++;
          $display("FAIL hold_ack_toggles: got %0d want 1",
                   ack_tog[0] - a0);
        end
        checks++;
        if (data_dw !== 32'h0000_1a25) begin
          errors++;
          $display("FAIL hold_data: got %h want 00001a25",
                   data_dw);
        end
        ds_hold = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL hold_count: got %0d want %0d",
               out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL hold_flit %0d: got %h want %h",
                 i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gen_enable();
    int r0;
    do_reset();
    clear_pkts();
    pkt[3] = {32'h0000_0005, 32'h0000_0cc2};
    pkt[1] = {32'h0000_0007};
    model_order();
    gen_enable = 1'b0;
    r0 = req_tog;
    fork
      send_port(1);
      send_port(3);
      begin
        repeat (20) @(negedge clk);
        checks++;
        if (out_q.size() != 0 || req_tog != r0) begin
          errors++;
          $display("FAIL gen_off: flits=%0d toggles=%0d want 0",
                   out_q.size(), req_tog - r0);
        end
        gen_enable = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gen_count: got %0d want %0d",
               out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gen_flit %0d: got %h want %h",
                 i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [W-1:0] fl [3];
    fl = '{32'h0000_0401, 32'h0, 32'hFFFF_FFFC};
    do_reset();
    clear_pkts();
    ds_rand = 1'b0;
    pe_b[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dup[1]   = fl[k];
      req_b[1] = ~req_b[1];
      t = 0;
      while (ack_up[1] !== req_b[1] && t < 400) begin
        @(negedge clk);
        t++;
      end
    end
    t = 0;
    while (out_q.size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (out_q.size() != 2) begin
      errors++;
      $display("FAIL mid_pre_count: got %0d want 2",
               out_q.size());
    end
    dup[1]   = fl[2];
    req_b[1] = ~req_b[1];
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack_up, req_dw, tailp} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_ctl: got %b want 0",
               {ack_up, req_dw, tailp});
    end
    checks++;
    if (data_dw !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got %h want 0", data_dw);
    end
    do_reset();
    pkt[1] = {32'h0000_1a25, 32'h1234_5670, 32'h0000_0002};
    model_order();
    send_all();
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_count: got %0d want %0d",
               out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_flit %0d: got %h want %h",
                 i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    logic [W-1:0] r;
    logic [1:0] kd;
    ds_rand = 1'b1;
    for (int round = 0; round < 8; round++) begin
      clear_pkts();
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(1, 0) == 1 || p == round % 4) begin
          len = $urandom_range(5, 1);
          for (int k = 0; k < len; k++) begin
            r = $urandom;
            if (len == 1) kd = 2'b11;
            else if (k == 0) kd = 2'b01;
            else if (k == len - 1) kd = 2'b10;
            else kd = 2'b00;
            pkt[p].push_back({r[W-1:2], kd});
          end
        end
      end
      model_order();
      out_q.delete();
      send_all();
      checks++;
      if (out_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d want %0d",
                 round, out_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
        checks++;
        if (out_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_flit %0d: got %h want %h",
                   round, i, out_q[i], exp_q[i]);
        end
      end
    end
    ds_rand = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    gen_enable = 1'b1;
    test_reset();
    test_single();
    test_all_ports();
    test_backpressure();
    test_gen_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
